// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag layout and helpers for the pipelined ALU
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Ops that have a 32-bit "W" form on a 64-bit datapath.
  function automatic logic word_ok(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLL) ||
           (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational RV64I/RV32I integer ALU with NZCV flags
// One shared adder (A + ~B + 1 for subtract-like ops) serves ADD, SUB, SLT and SLTU.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  input  logic            i_w,
  output logic [XLEN-1:0] o_result,
  output flags_t          o_flags,
  output logic            o_err
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e         w_op;
  logic            w_sub;
  logic [XLEN-1:0] w_b_eff;
  logic [32:0]     w_sum_lo;
  logic [XLEN:0]   w_sum;
  logic            w_c_full, w_v_full, w_c_word, w_v_word, w_lt, w_ltu;
  logic [SHW-1:0]  w_shamt;
  logic [4:0]      w_shamt_w;
  logic [XLEN-1:0] w_sll, w_srl, w_sra;
  logic [31:0]     w_sllw, w_srlw, w_sraw;
  logic [XLEN-1:0] w_res;
  logic            w_err, w_c, w_v;

  assign w_op    = alu_op_e'(i_op);
  assign w_sub   = (w_op == ALU_SUB) || (w_op == ALU_SLT) || (w_op == ALU_SLTU);
  assign w_b_eff = w_sub ? ~i_b : i_b;

  // Adder split at bit 32 so the word-op carry is a real wire, not a re-derivation.
  assign w_sum_lo = {1'b0, i_a[31:0]} + {1'b0, w_b_eff[31:0]} + {32'b0, w_sub};

  generate
    if (XLEN > 32) begin : g_hi
      logic [XLEN-32:0] w_sum_hi;
      assign w_sum_hi = {1'b0, i_a[XLEN-1:32]} + {1'b0, w_b_eff[XLEN-1:32]} +
                        {{(XLEN-32){1'b0}}, w_sum_lo[32]};
      assign w_sum    = {w_sum_hi, w_sum_lo[31:0]};
    end else begin : g_lo
      assign w_sum = w_sum_lo;
    end
  endgenerate

  assign w_c_full = w_sum[XLEN];
  assign w_v_full = (i_a[XLEN-1] == w_b_eff[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
  assign w_c_word = w_sum_lo[32];
  assign w_v_word = (i_a[31] == w_b_eff[31]) && (w_sum_lo[31] != i_a[31]);
  assign w_lt     = w_sum[XLEN-1] ^ w_v_full;
  assign w_ltu    = ~w_c_full;

  assign w_shamt   = i_b[SHW-1:0];
  assign w_shamt_w = i_b[4:0];
  assign w_sll     = i_a << w_shamt;
  assign w_srl     = i_a >> w_shamt;
  assign w_sra     = $signed(i_a) >>> w_shamt;
  assign w_sllw    = i_a[31:0] << w_shamt_w;
  assign w_srlw    = i_a[31:0] >> w_shamt_w;
  assign w_sraw    = $signed(i_a[31:0]) >>> w_shamt_w;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    if (i_w) begin
      if (XLEN != 64 || !word_ok(w_op)) begin
        w_err = 1'b1;
      end else begin
        case (w_op)
          ALU_ADD, ALU_SUB: begin
            w_res = sext32(w_sum[31:0]);
            w_c   = w_c_word;
            w_v   = w_v_word;
          end
          ALU_SLL: w_res = sext32(w_sllw);
          ALU_SRL: w_res = sext32(w_srlw);
          ALU_SRA: w_res = sext32(w_sraw);
          default: w_res = '0;
        endcase
      end
    end else begin
      case (w_op)
        ALU_AND:   w_res = i_a & i_b;
        ALU_OR:    w_res = i_a | i_b;
        ALU_XOR:   w_res = i_a ^ i_b;
        ALU_ADD, ALU_SUB: begin
          w_res = w_sum[XLEN-1:0];
          w_c   = w_c_full;
          w_v   = w_v_full;
        end
        ALU_SLL:   w_res = w_sll;
        ALU_SRL:   w_res = w_srl;
        ALU_SRA:   w_res = w_sra;
        ALU_SLT:   w_res = {{(XLEN-1){1'b0}}, w_lt};
        ALU_SLTU:  w_res = {{(XLEN-1){1'b0}}, w_ltu};
        ALU_PASSB: w_res = i_b;
        default:   w_err = 1'b1;
      endcase
    end
  end

  assign o_result  = w_res;
  assign o_err     = w_err;
  assign o_flags.n = w_err ? 1'b0 : w_res[XLEN-1];
  assign o_flags.z = w_err ? 1'b0 : (w_res == '0);
  assign o_flags.c = w_c;
  assign o_flags.v = w_v;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - valid/ready pipelined ALU, 1 or 2 register stages around alu_core
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] Ain,
  input  logic [XLEN-1:0] Bin,
  input  logic [3:0]      ALUop,
  input  logic            op_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic [3:0]      flags,
  output logic            err
);

  logic [XLEN-1:0] w_core_a, w_core_b, w_res;
  logic [3:0]      w_core_op;
  logic            w_core_w, w_err, w_s0_valid, w_s1_ready;
  flags_t          w_flags;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out;
  flags_t          r_flags;
  logic            r_err;

  assign w_s1_ready = !r_out_valid || out_ready;

  generate
    if (STAGES == 2) begin : g_two
      logic            r_s0_valid;
      logic [XLEN-1:0] r_a, r_b;
      logic [3:0]      r_op;
      logic            r_w;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_s0_valid <= 1'b0;
        else if (in_ready) r_s0_valid <= in_valid;
      end

      // Operand registers carry no reset; r_s0_valid qualifies them.
      always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
          r_a  <= Ain;
          r_b  <= Bin;
          r_op <= ALUop;
          r_w  <= op_w;
        end
      end

      assign in_ready   = !r_s0_valid || w_s1_ready;
      assign w_s0_valid = r_s0_valid;
      assign w_core_a   = r_a;
      assign w_core_b   = r_b;
      assign w_core_op  = r_op;
      assign w_core_w   = r_w;
    end else begin : g_one
      assign in_ready   = w_s1_ready;
      assign w_s0_valid = in_valid;
      assign w_core_a   = Ain;
      assign w_core_b   = Bin;
      assign w_core_op  = ALUop;
      assign w_core_w   = op_w;
    end
  endgenerate

  alu_core #(.XLEN(XLEN)) u_core (
    .i_a      (w_core_a),
    .i_b      (w_core_b),
    .i_op     (w_core_op),
    .i_w      (w_core_w),
    .o_result (w_res),
    .o_flags  (w_flags),
    .o_err    (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
    end else if (w_s1_ready) begin
      r_out_valid <= w_s0_valid;
      if (w_s0_valid) begin
        r_out   <= w_res;
        r_flags <= w_flags;
        r_err   <= w_err;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out           = r_out;
  assign err           = r_err;
  assign flags[FLAG_N] = r_flags.n;
  assign flags[FLAG_Z] = r_flags.z;
  assign flags[FLAG_C] = r_flags.c;
  assign flags[FLAG_V] = r_flags.v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (64-bit two-stage and 32-bit one-stage builds)
module tb_alu_pipe;

  typedef struct packed {
    logic [63:0] out;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op_w, out_valid, out_ready, err;
  logic [63:0] a, b, res;
  logic [3:0]  op, flg;

  logic        v32, rdy32, w32, ov32, ordy32, err32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  op32, flg32;

  exp_t sb[$];
  exp_t hold, mon_e;
  logic have_hold = 1'b0;
  logic rand_ready = 1'b0;
  int   total = 0, bad = 0, rx_count = 0, stall_cycles = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(64), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(a), .Bin(b), .ALUop(op), .op_w(op_w),
    .out_valid(out_valid), .out_ready(out_ready), .out(res), .flags(flg), .err(err)
  );

  alu_pipe #(.XLEN(32), .STAGES(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
    .Ain(a32), .Bin(b32), .ALUop(op32), .op_w(w32),
    .out_valid(ov32), .out_ready(ordy32), .out(res32), .flags(flg32), .err(err32)
  );

  function automatic exp_t mk(input logic [63:0] o, input logic [3:0] f, input logic e);
    exp_t x;
    x.out = o; x.flags = f; x.err = e;
    return x;
  endfunction

  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic [3:0] mop, input logic mw);
    exp_t e;
    logic [64:0] u;
    logic signed [64:0] s;
    logic [32:0] u32;
    logic signed [32:0] s32;
    logic [31:0] r32;
    logic [63:0] r;
    logic c, v;
    e = '0; r = '0; r32 = '0; c = 1'b0; v = 1'b0;
    if (mw) begin
      case (mop)
        4'b0010: begin
          u32 = {1'b0, ma[31:0]} + {1'b0, mb[31:0]};
          s32 = $signed({ma[31], ma[31:0]}) + $signed({mb[31], mb[31:0]});
          r32 = u32[31:0]; c = u32[32]; v = s32[32] ^ s32[31];
        end
        4'b0110: begin
          r32 = ma[31:0] - mb[31:0];
          c   = ma[31:0] >= mb[31:0];
          s32 = $signed({ma[31], ma[31:0]}) - $signed({mb[31], mb[31:0]});
          v   = s32[32] ^ s32[31];
        end
        4'b0100: r32 = ma[31:0] << mb[4:0];
        4'b0101: r32 = ma[31:0] >> mb[4:0];
        4'b0111: r32 = $signed(ma[31:0]) >>> mb[4:0];
        default: begin e.err = 1'b1; return e; end
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (mop)
        4'b0000: r = ma & mb;
        4'b0001: r = ma | mb;
        4'b0011: r = ma ^ mb;
        4'b0010: begin
          u = {1'b0, ma} + {1'b0, mb};
          s = $signed({ma[63], ma}) + $signed({mb[63], mb});
          r = u[63:0]; c = u[64]; v = s[64] ^ s[63];
        end
        4'b0110: begin
          r = ma - mb; c = ma >= mb;
          s = $signed({ma[63], ma}) - $signed({mb[63], mb});
          v = s[64] ^ s[63];
        end
        4'b0100: r = ma << mb[5:0];
        4'b0101: r = ma >> mb[5:0];
        4'b0111: r = $signed(ma) >>> mb[5:0];
        4'b1000: r = {63'b0, $signed(ma) < $signed(mb)};
        4'b1001: r = {63'b0, ma < mb};
        4'b1010: r = mb;
        default: begin e.err = 1'b1; return e; end
      endcase
    end
    e.out = r;
    e.flags = {r[63], r == 64'b0, c, v};
    return e;
  endfunction

  always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  // Output monitor: decides at negedge+3 whether the coming posedge transfers a beat.
  always @(negedge clk) begin
    #3;
    if (rst || !out_valid) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        total++;
        if (res !== hold.out || flg !== hold.flags || err !== hold.err) begin
          bad++;
          $display("FAIL stall_stable got=%h/%b/%b held=%h/%b/%b", res, flg, err, hold.out, hold.flags, hold.err);
        end
      end
      if (out_ready) begin
        have_hold = 1'b0;
        rx_count++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got out=%h flags=%b err=%b", res, flg, err);
        end else begin
          mon_e = sb.pop_front();
          if (res !== mon_e.out || flg !== mon_e.flags || err !== mon_e.err) begin
            bad++;
            $display("FAIL result got out=%h flags=%b err=%b exp out=%h flags=%b err=%b",
                     res, flg, err, mon_e.out, mon_e.flags, mon_e.err);
          end
        end
      end else begin
        hold.out = res; hold.flags = flg; hold.err = err;
        have_hold = 1'b1;
      end
    end
  end

  task automatic send(input logic [63:0] sa, input logic [63:0] sbv, input logic [3:0] sop,
                      input logic sw, input exp_t e);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; a = sa; b = sbv; op = sop; op_w = sw;
    #3;
    while (!in_ready && n < 200) begin
      stall_cycles++;
      @(negedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #3;
    total++;
    if (out_valid !== 1'b0 || res !== 64'b0 || flg !== 4'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b out=%h flags=%b err=%b required 0", out_valid, res, flg, err);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    total++;
    if (in_ready !== 1'b1 || rdy32 !== 1'b1 || ov32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got in_ready=%b/%b ov32=%b required 1/1/0", in_ready, rdy32, ov32);
    end
  endtask

  task automatic test_vectors;
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b0, mk(64'h0, 4'b0110, 1'b0));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b0, mk(64'h8000_0000_0000_0000, 4'b1001, 1'b0));
    send(64'd5, 64'd7, 4'b0110, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0));
    send(64'd7, 64'd5, 4'b0110, 1'b0, mk(64'd2, 4'b0010, 1'b0));
    send(64'd5, 64'd5, 4'b0110, 1'b0, mk(64'd0, 4'b0110, 1'b0));
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 1'b0, mk(64'd1, 4'b0000, 1'b0));
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, mk(64'd0, 4'b0100, 1'b0));
    send(64'hF0F0, 64'h0FF0, 4'b0000, 1'b0, mk(64'h00F0, 4'b0000, 1'b0));
    send(64'hF0F0, 64'h0FF0, 4'b0011, 1'b0, mk(64'hFF00, 4'b0000, 1'b0));
    send(64'd1, 64'd63, 4'b0100, 1'b0, mk(64'h8000_0000_0000_0000, 4'b1000, 1'b0));
    send(64'd1, 64'd65, 4'b0100, 1'b0, mk(64'd2, 4'b0000, 1'b0));
    send(64'h8000_0000_0000_0000, 64'd63, 4'b0101, 1'b0, mk(64'd1, 4'b0000, 1'b0));
    send(64'h8000_0000_0000_0000, 64'd4, 4'b0111, 1'b0, mk(64'hF800_0000_0000_0000, 4'b1000, 1'b0));
    send(64'd3, 64'h1234, 4'b1010, 1'b0, mk(64'h1234, 4'b0000, 1'b0));
    drain("vectors");
  endtask

  task automatic test_word_ops;
    out_ready = 1'b1;
    send(64'h7FFF_FFFF, 64'd1, 4'b0010, 1'b1, mk(64'hFFFF_FFFF_8000_0000, 4'b1001, 1'b0));
    send(64'h8000_0000, 64'd4, 4'b0111, 1'b1, mk(64'hFFFF_FFFF_F800_0000, 4'b1000, 1'b0));
    send(64'h1234_5678_0000_0000, 64'd1, 4'b0110, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0));
    send(64'd1, 64'd63, 4'b0100, 1'b1, mk(64'hFFFF_FFFF_8000_0000, 4'b1000, 1'b0));
    send(64'hFFFF_FFFF_8000_0000, 64'd4, 4'b0101, 1'b1, mk(64'h0800_0000, 4'b0000, 1'b0));
    drain("word_ops");
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    send(64'd9, 64'd3, 4'b1111, 1'b0, mk(64'h0, 4'b0000, 1'b1));
    send(64'd9, 64'd3, 4'b0011, 1'b1, mk(64'h0, 4'b0000, 1'b1));
    send(64'd9, 64'd3, 4'b1000, 1'b1, mk(64'h0, 4'b0000, 1'b1));
    send(64'd0, 64'd0, 4'b1011, 1'b0, mk(64'h0, 4'b0000, 1'b1));
    drain("illegal");
  endtask

  task automatic test_back_to_back;
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    out_ready = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rop = 4'($urandom_range(0, 10));
      send(ra, rb, rop, 1'b0, model(ra, rb, rop, 1'b0));
    end
    total++;
    if (stall_cycles != 0) begin
      bad++;
      $display("FAIL back_to_back stall_cycles=%0d required=0", stall_cycles);
    end
    drain("back_to_back");
  endtask

  task automatic test_stream;
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    logic        rw;
    int          rx0;
    rx0 = rx_count;
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rop = 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 3) == 0);
      send(ra, rb, rop, rw, model(ra, rb, rop, rw));
    end
    drain("stream");
    rand_ready = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rx_count - rx0 != 10) begin
      bad++;
      $display("FAIL stream_count got=%0d required=10", rx_count - rx0);
    end
  endtask

  task automatic test_reset_in_flight;
    out_ready = 1'b0;
    send(64'd10, 64'd20, 4'b0010, 1'b0, mk(64'd30, 4'b0000, 1'b0));
    send(64'd1, 64'd2, 4'b0001, 1'b0, mk(64'd3, 4'b0000, 1'b0));
    @(negedge clk); #3;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL inflight_full got v=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || res !== 64'b0 || flg !== 4'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL inflight_reset got v=%b out=%h flags=%b err=%b required 0", out_valid, res, flg, err);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #3;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got in_ready=%b v=%b required 1/0", in_ready, out_valid);
    end
    send(64'd100, 64'd1, 4'b0110, 1'b0, mk(64'd99, 4'b0010, 1'b0));
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_edge1 out_valid=%b required=0", out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_edge2 out_valid=%b required=1", out_valid);
    end
    drain("reset_in_flight");
  endtask

  task automatic test_x32;
    logic [31:0] ta[5], tb_[5], te_out[5];
    logic [3:0]  top[5], te_f[5];
    logic        tw[5], te_e[5];
    ta = '{32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF};
    tb_ = '{32'd1, 32'd3, 32'd33, 32'd31, 32'd1};
    top = '{4'b0010, 4'b0010, 4'b0100, 4'b0111, 4'b0010};
    tw = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    te_out = '{32'h0, 32'h0, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000};
    te_f = '{4'b0110, 4'b0000, 4'b0000, 4'b1000, 4'b1001};
    te_e = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ordy32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v32 = 1'b1; a32 = ta[i]; b32 = tb_[i]; op32 = top[i]; w32 = tw[i];
      @(posedge clk); #1;
      v32 = 1'b0;
      total++;
      if (ov32 !== 1'b1 || res32 !== te_out[i] || flg32 !== te_f[i] || err32 !== te_e[i]) begin
        bad++;
        $display("FAIL x32_case%0d got v=%b out=%h flags=%b err=%b exp v=1 out=%h flags=%b err=%b",
                 i, ov32, res32, flg32, err32, te_out[i], te_f[i], te_e[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (ov32 !== 1'b0) begin
      bad++;
      $display("FAIL x32_empty out_valid=%b required=0", ov32);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = '0; op_w = 1'b0; out_ready = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; w32 = 1'b0; ordy32 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_vectors;
    test_word_ops;
    test_illegal;
    test_back_to_back;
    test_stream;
    test_reset_in_flight;
    test_x32;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
